seat_request_scheduler: RTL and testbench
=========================================

Name: seat_request_scheduler

Overview:
- Front-end controller for the seat-table memory. Collects check-in, state-change and checkout requests from N_KIOSK card-reader kiosks and configuration commands from the manager console.
- Arbitrates these requests and serialises them into single-cycle write strobes on the memory's command bus.
- Owns the simulated wall clock (Time_mem) and the registered ban and limit-time settings that the memory reads continuously.

Parameters:
- N_KIOSK, 4, number of kiosk requesters.
- TICKS_PER_MIN, 60, clk cycles per simulated minute.
- DEFAULT_LIMIT, 120, reset value of limit_time_mem, in minutes.

Ports:
- clk  in  1  single system clock; all state rises on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- kiosk_req  in  N_KIOSK  per-kiosk request; held high until granted.
- kiosk_student  in  N_KIOSK*32  student number per kiosk; kiosk k in bits [32k+31:32k].
- kiosk_seat  in  N_KIOSK*5  seat number 0..31 per kiosk.
- kiosk_state  in  N_KIOSK*2  requested seat state per kiosk (0 free, 1 reserved, 2 occupied).
- kiosk_gnt  out  N_KIOSK  one-hot, one-cycle grant; the payload is captured in this cycle.
- mgr_req  in  1  manager command request; held until mgr_ack.
- mgr_cmd  in  2  0 nop, 1 set ban, 2 set limit, 3 clear table.
- mgr_ban  in  2  ban pattern: 0 ban even seats, 1 ban odd seats, 2 no ban.
- mgr_limit  in  11  new limit time in minutes.
- mgr_ack  out  1  one-cycle pulse when the manager command completes.
- write_mem  out  1  kiosk write strobe.
- write_set_mem  out  2  manager config strobe: 1 ban, 2 limit, 0 none.
- rst_mem  out  1  table-clear strobe, active high.
- Student_No_mem  out  32  issued student number.
- Seat_No_mem  out  5  issued seat number.
- Seat_State_mem  out  2  issued seat state.
- ban_mem  out  2  current ban setting.
- limit_time_mem  out  11  current limit time.
- Time_mem  out  11  minutes since midnight, 0..1439.

Behaviour:
- Reset is asynchronous on rst_n low. All outputs are registered. Reset values:
  - kiosk_gnt, mgr_ack, write_mem, write_set_mem, rst_mem, Student_No_mem, Seat_No_mem, Seat_State_mem: 0.
  - ban_mem: 2. limit_time_mem: DEFAULT_LIMIT. Time_mem: 0.
  - FSM goes to IDLE; the round-robin pointer selects kiosk 0 first.
- Clock:
  - The tick counter counts 0..TICKS_PER_MIN-1.
  - On the terminal count, Time_mem increments and wraps from 1439 to 0.
  - The clock runs freely and is independent of the FSM.
- FSM has three states: IDLE, ISSUE, HOLD.
- IDLE:
  - If mgr_req is high, latch mgr_cmd, mgr_ban and mgr_limit; go to ISSUE.
  - Else if any kiosk_req is high, grant the first requester at or after rr_ptr, modulo N_KIOSK. Pulse kiosk_gnt[k], latch kiosk k's payload, set rr_ptr = k+1 mod N_KIOSK, go to ISSUE.
  - Else stay in IDLE.
- ISSUE (exactly one cycle):
  - Kiosk command: write_mem=1 with the latched Student_No_mem, Seat_No_mem and Seat_State_mem.
  - cmd 1: ban_mem is updated to the latched ban; write_set_mem=1.
  - cmd 2: limit_time_mem is updated; write_set_mem=2.
  - cmd 3: rst_mem=1.
  - cmd 0: no strobe.
  - Go to HOLD.
- HOLD (exactly one cycle):
  - All strobes are 0. This gap is mandatory because the memory is level-sensitive.
  - mgr_ack pulses if the command came from the manager.
  - Go to IDLE.
- Throughput: one command per 3 cycles (IDLE grant, ISSUE, HOLD). Grant-to-strobe latency is 1 cycle.
- Priority:
  - The manager always beats kiosks when both request in the same IDLE cycle.
  - Kiosks are round-robin, so any kiosk waits at most N_KIOSK grants.
- Payload outputs hold their last issued values between commands. ban_mem and limit_time_mem persist until the next manager command or reset.
- Requests arriving in ISSUE or HOLD are not sampled; they are considered at the next IDLE.
- A requester dropping kiosk_req before its grant is never granted. A dropped request is not an error.
- Asserting rst_n low mid-command aborts it: no strobe and no ack for the aborted command, and rr_ptr returns to 0.
- mgr_limit is passed through unchecked; 0 is legal and means immediate expiry.
- mgr_ban value 3 is treated as 2.

Decomposition:
- Package seat_ctrl_pkg contains:
  - state enum {IDLE, ISSUE, HOLD} and mgr_cmd enum {CMD_NOP, CMD_BAN, CMD_LIMIT, CMD_CLEAR}.
  - Width constants STUDENT_W=32, SEAT_W=5, TIME_W=11.
  - Constants DAY_MIN=1440, BAN_NONE=2.
- Sub-module seat_clock contains the tick counter and the Time_mem counter, and is parameterised by TICKS_PER_MIN.
- Arbitration and FSM remain in the top level.

Test Plan:
- Reset, then run 60*TICKS_PER_MIN cycles -> Time_mem reaches 60. Preload the count at 1439 and advance one minute -> Time_mem reads 0.
- kiosk 2 requests student 2021001, seat 7, state 1 -> kiosk_gnt=0100 for one cycle. The next cycle has write_mem=1 with 2021001/7/1. The cycle after has write_mem=0.
- All four kiosks request continuously -> grants in order 0,1,2,3,0, exactly 3 cycles apart, with exactly one write strobe each.
- mgr_req with cmd 1, ban 1, same cycle as kiosk 0 -> the manager wins: ban_mem=1, write_set_mem=1 for one cycle, mgr_ack in the following cycle. Kiosk 0 is granted at the next IDLE.
- Manager cmd 2 with limit 30, then cmd 3 -> limit_time_mem=30 with write_set_mem=2 pulsed. Then rst_mem pulses for one cycle, and limit_time_mem stays 30.
- Assert rst_n low during ISSUE of a kiosk command -> strobes drop to 0 immediately with no ack. All outputs show reset values, including ban_mem=2 and limit_time_mem=120.

Source files
------------

// File: rtl/seat_ctrl_pkg.sv
// Shared types and constants for the seat-table request scheduler.
package seat_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
  typedef enum logic [1:0] {CMD_NOP, CMD_BAN, CMD_LIMIT, CMD_CLEAR} mgr_cmd_t;

  localparam int STUDENT_W = 32;
  localparam int SEAT_W    = 5;
  localparam int TIME_W    = 11;
  localparam int DAY_MIN   = 1440;

  localparam logic [1:0] BAN_NONE = 2'd2;

  // Pattern 3 has no meaning to the memory, so it is folded onto "no ban".
  function automatic logic [1:0] sanitize_ban(input logic [1:0] ban);
    return (ban == 2'd3) ? BAN_NONE : ban;
  endfunction

endpackage

// File: rtl/seat_clock.sv
// Free-running simulated wall clock: minutes since midnight, wrapping at one day.
module seat_clock
  import seat_ctrl_pkg::*;
#(
  parameter int TICKS_PER_MIN = 60
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [TIME_W-1:0] time_min
);

  localparam int TICK_W = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;

  logic [TICK_W-1:0] tick_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      time_min <= '0;
    end else if (tick_cnt == TICK_W'(TICKS_PER_MIN - 1)) begin
      tick_cnt <= '0;
      time_min <= (time_min == TIME_W'(DAY_MIN - 1)) ? '0 : time_min + TIME_W'(1);
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

endmodule

// File: rtl/seat_request_scheduler.sv
// Arbitrates kiosk and manager requests into single-cycle strobes on the seat-table command bus.
module seat_request_scheduler
  import seat_ctrl_pkg::*;
#(
  parameter int N_KIOSK       = 4,
  parameter int TICKS_PER_MIN = 60,
  parameter int DEFAULT_LIMIT = 120
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_KIOSK-1:0]             kiosk_req,
  input  logic [N_KIOSK*STUDENT_W-1:0]   kiosk_student,
  input  logic [N_KIOSK*SEAT_W-1:0]      kiosk_seat,
  input  logic [N_KIOSK*2-1:0]           kiosk_state,
  output logic [N_KIOSK-1:0]             kiosk_gnt,
  input  logic                           mgr_req,
  input  logic [1:0]                     mgr_cmd,
  input  logic [1:0]                     mgr_ban,
  input  logic [TIME_W-1:0]              mgr_limit,
  output logic                           mgr_ack,
  output logic                           write_mem,
  output logic [1:0]                     write_set_mem,
  output logic                           rst_mem,
  output logic [STUDENT_W-1:0]           Student_No_mem,
  output logic [SEAT_W-1:0]              Seat_No_mem,
  output logic [1:0]                     Seat_State_mem,
  output logic [1:0]                     ban_mem,
  output logic [TIME_W-1:0]              limit_time_mem,
  output logic [TIME_W-1:0]              Time_mem
);

  localparam int IDX_W = (N_KIOSK > 1) ? $clog2(N_KIOSK) : 1;

  state_t                 state;
  logic [IDX_W-1:0]       rr_ptr;
  logic                   from_mgr;
  mgr_cmd_t               cmd_q;
  logic [1:0]             ban_q;
  logic [TIME_W-1:0]      limit_q;
  logic [STUDENT_W-1:0]   pay_student;
  logic [SEAT_W-1:0]      pay_seat;
  logic [1:0]             pay_state;

  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_idx;
  logic [N_KIOSK-1:0]     pick_onehot;
  logic [IDX_W-1:0]       next_ptr;

  seat_clock #(.TICKS_PER_MIN(TICKS_PER_MIN)) u_clock (
    .clk      (clk),
    .rst_n    (rst_n),
    .time_min (Time_mem)
  );

  // Round-robin search: first requester at or after rr_ptr, wrapping.
  always_comb begin
    pick_valid  = 1'b0;
    pick_idx    = '0;
    pick_onehot = '0;
    for (int i = 0; i < N_KIOSK; i++) begin
      if (!pick_valid && kiosk_req[(int'(rr_ptr) + i) % N_KIOSK]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'((int'(rr_ptr) + i) % N_KIOSK);
      end
    end
    pick_onehot[pick_idx] = pick_valid;
    next_ptr = IDX_W'((int'(pick_idx) + 1) % N_KIOSK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      from_mgr       <= 1'b0;
      cmd_q          <= CMD_NOP;
      ban_q          <= BAN_NONE;
      limit_q        <= '0;
      pay_student    <= '0;
      pay_seat       <= '0;
      pay_state      <= '0;
      kiosk_gnt      <= '0;
      mgr_ack        <= 1'b0;
      write_mem      <= 1'b0;
      write_set_mem  <= 2'd0;
      rst_mem        <= 1'b0;
      Student_No_mem <= '0;
      Seat_No_mem    <= '0;
      Seat_State_mem <= '0;
      ban_mem        <= BAN_NONE;
      limit_time_mem <= TIME_W'(DEFAULT_LIMIT);
    end else begin
      kiosk_gnt     <= '0;
      mgr_ack       <= 1'b0;
      write_mem     <= 1'b0;
      write_set_mem <= 2'd0;
      rst_mem       <= 1'b0;
      case (state)
        IDLE: begin
          if (mgr_req) begin
            from_mgr <= 1'b1;
            cmd_q    <= mgr_cmd_t'(mgr_cmd);
            ban_q    <= sanitize_ban(mgr_ban);
            limit_q  <= mgr_limit;
            state    <= ISSUE;
          end else if (pick_valid) begin
            from_mgr    <= 1'b0;
            kiosk_gnt   <= pick_onehot;
            pay_student <= kiosk_student[int'(pick_idx)*STUDENT_W +: STUDENT_W];
            pay_seat    <= kiosk_seat[int'(pick_idx)*SEAT_W +: SEAT_W];
            pay_state   <= kiosk_state[int'(pick_idx)*2 +: 2];
            rr_ptr      <= next_ptr;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (from_mgr) begin
            case (cmd_q)
              CMD_BAN: begin
                ban_mem       <= ban_q;
                write_set_mem <= 2'd1;
              end
              CMD_LIMIT: begin
                limit_time_mem <= limit_q;
                write_set_mem  <= 2'd2;
              end
              CMD_CLEAR: rst_mem <= 1'b1;
              default: ;
            endcase
          end else begin
            write_mem      <= 1'b1;
            Student_No_mem <= pay_student;
            Seat_No_mem    <= pay_seat;
            Seat_State_mem <= pay_state;
          end
          state <= HOLD;
        end
        // Strobes stay low here so the level-sensitive memory sees a clean gap.
        HOLD: begin
          mgr_ack <= from_mgr;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seat_request_scheduler.sv
// Scoreboard bench: stimulus pushes expected bus events, a monitor pops them as the DUT emits strobes.
module tb_seat_request_scheduler;

  typedef struct packed {
    logic [3:0]  gnt;
    logic        wr;
    logic [1:0]  wset;
    logic        rstm;
    logic        ack;
    logic [31:0] stu;
    logic [4:0]  seat;
    logic [1:0]  st;
    logic [1:0]  ban;
    logic [10:0] lim;
  } ev_t;

  logic         clk;
  logic         rst_n;
  logic [3:0]   kiosk_req;
  logic [127:0] kiosk_student;
  logic [19:0]  kiosk_seat;
  logic [7:0]   kiosk_state;
  logic [3:0]   kiosk_gnt;
  logic         mgr_req;
  logic [1:0]   mgr_cmd;
  logic [1:0]   mgr_ban;
  logic [10:0]  mgr_limit;
  logic         mgr_ack;
  logic         write_mem;
  logic [1:0]   write_set_mem;
  logic         rst_mem;
  logic [31:0]  Student_No_mem;
  logic [4:0]   Seat_No_mem;
  logic [1:0]   Seat_State_mem;
  logic [1:0]   ban_mem;
  logic [10:0]  limit_time_mem;
  logic [10:0]  Time_mem;

  int total = 0;
  int bad   = 0;
  ev_t expQ[$];
  int  gapQ[$];
  int  reqLeft[4];

  logic [31:0] mStu;
  logic [4:0]  mSeat;
  logic [1:0]  mSt;
  logic [1:0]  mBan;
  logic [10:0] mLim;

  seat_request_scheduler #(
    .N_KIOSK(4), .TICKS_PER_MIN(4), .DEFAULT_LIMIT(120)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .kiosk_req(kiosk_req), .kiosk_student(kiosk_student),
    .kiosk_seat(kiosk_seat), .kiosk_state(kiosk_state), .kiosk_gnt(kiosk_gnt),
    .mgr_req(mgr_req), .mgr_cmd(mgr_cmd), .mgr_ban(mgr_ban),
    .mgr_limit(mgr_limit), .mgr_ack(mgr_ack),
    .write_mem(write_mem), .write_set_mem(write_set_mem), .rst_mem(rst_mem),
    .Student_No_mem(Student_No_mem), .Seat_No_mem(Seat_No_mem),
    .Seat_State_mem(Seat_State_mem), .ban_mem(ban_mem),
    .limit_time_mem(limit_time_mem), .Time_mem(Time_mem)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic ev_t baseEv();
    ev_t e;
    e      = '0;
    e.stu  = mStu;
    e.seat = mSeat;
    e.st   = mSt;
    e.ban  = mBan;
    e.lim  = mLim;
    return e;
  endfunction

  task automatic pushExp(input ev_t e, input int gap);
    expQ.push_back(e);
    gapQ.push_back(gap);
  endtask

  task automatic expKiosk(input int k, input int gap, input logic [31:0] stu,
                          input logic [4:0] seat, input logic [1:0] st);
    ev_t e;
    e     = baseEv();
    e.gnt = 4'b0001 << k;
    pushExp(e, gap);
    mStu  = stu;
    mSeat = seat;
    mSt   = st;
    e     = baseEv();
    e.wr  = 1'b1;
    pushExp(e, 1);
  endtask

  task automatic expMgr(input int cmd, input logic [1:0] ban, input logic [10:0] lim, input int gap);
    ev_t e;
    if (cmd == 1) mBan = (ban == 2'd3) ? 2'd2 : ban;
    if (cmd == 2) mLim = lim;
    e = baseEv();
    if (cmd == 1) e.wset = 2'd1;
    if (cmd == 2) e.wset = 2'd2;
    if (cmd == 3) e.rstm = 1'b1;
    if (cmd != 0) begin
      pushExp(e, gap);
      e = baseEv();
      e.ack = 1'b1;
      pushExp(e, 1);
    end else begin
      e.ack = 1'b1;
      pushExp(e, gap);
    end
  endtask

  task automatic kioskReq(input int k, input logic [31:0] stu, input logic [4:0] seat,
                          input logic [1:0] st, input int cnt);
    kiosk_student[k*32 +: 32] = stu;
    kiosk_seat[k*5 +: 5]      = seat;
    kiosk_state[k*2 +: 2]     = st;
    reqLeft[k]                = cnt;
    kiosk_req[k]              = 1'b1;
  endtask

  task automatic mgrCommand(input logic [1:0] cmd, input logic [1:0] ban, input logic [10:0] lim);
    mgr_cmd   = cmd;
    mgr_ban   = ban;
    mgr_limit = lim;
    mgr_req   = 1'b1;
  endtask

  // Plays the requester side until every request has been served, then lets the bus drain.
  task automatic applyStimulus(input int maxCycles);
    int n = 0;
    while ((kiosk_req != 4'b0 || mgr_req) && n < maxCycles) begin
      @(negedge clk);
      n++;
      for (int k = 0; k < 4; k++) begin
        if (kiosk_gnt[k]) begin
          reqLeft[k]--;
          if (reqLeft[k] == 0) kiosk_req[k] = 1'b0;
        end
      end
      if (mgr_ack) mgr_req = 1'b0;
    end
    checkOutput("requests_drained", {59'd0, kiosk_req, mgr_req}, 64'd0);
    kiosk_req = '0;
    mgr_req   = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_gnt"},   kiosk_gnt, 0);
    checkOutput({tag, "_ack"},   mgr_ack, 0);
    checkOutput({tag, "_wr"},    write_mem, 0);
    checkOutput({tag, "_wset"},  write_set_mem, 0);
    checkOutput({tag, "_rstm"},  rst_mem, 0);
    checkOutput({tag, "_stu"},   Student_No_mem, 0);
    checkOutput({tag, "_seat"},  Seat_No_mem, 0);
    checkOutput({tag, "_state"}, Seat_State_mem, 0);
    checkOutput({tag, "_ban"},   ban_mem, 2);
    checkOutput({tag, "_limit"}, limit_time_mem, 120);
    checkOutput({tag, "_time"},  Time_mem, 0);
  endtask

  // Monitor: every cycle with any strobe or grant must match the next queued event.
  initial begin
    int cyc     = 0;
    int lastCyc = 0;
    ev_t act, exp;
    int gap;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n && (kiosk_gnt != 4'b0 || write_mem || write_set_mem != 2'd0 || rst_mem || mgr_ack)) begin
        act = {kiosk_gnt, write_mem, write_set_mem, rst_mem, mgr_ack, Student_No_mem,
               Seat_No_mem, Seat_State_mem, ban_mem, limit_time_mem};
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_event: got=%h expected=none", act);
        end else begin
          exp = expQ.pop_front();
          gap = gapQ.pop_front();
          checkOutput("bus_event", act, exp);
          if (gap >= 0) checkOutput("event_spacing", cyc - lastCyc, gap);
        end
        lastCyc = cyc;
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    kiosk_req = '0; kiosk_student = '0; kiosk_seat = '0; kiosk_state = '0;
    mgr_req = 1'b0; mgr_cmd = '0; mgr_ban = '0; mgr_limit = '0;
    for (int k = 0; k < 4; k++) reqLeft[k] = 0;
    mStu = '0; mSeat = '0; mSt = '0; mBan = 2'd2; mLim = 11'd120;

    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;

    // Wall clock: 4 ticks per minute in this bench.
    repeat (240) @(posedge clk);
    @(negedge clk);
    checkOutput("time_60", Time_mem, 60);
    repeat ((1439 - 60) * 4) @(posedge clk);
    @(negedge clk);
    checkOutput("time_1439", Time_mem, 1439);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("time_wrap", Time_mem, 0);

    $display("[TB] single kiosk requests");
    kioskReq(2, 32'd2021001, 5'd7, 2'd1, 1);
    expKiosk(2, -1, 32'd2021001, 5'd7, 2'd1);
    applyStimulus(50);
    kioskReq(3, 32'hFFFF_FFFF, 5'd31, 2'd2, 1);
    expKiosk(3, -1, 32'hFFFF_FFFF, 5'd31, 2'd2);
    applyStimulus(50);

    $display("[TB] all kiosks continuous");
    kioskReq(0, 32'd100, 5'd0,  2'd2, 2);
    kioskReq(1, 32'd200, 5'd31, 2'd2, 1);
    kioskReq(2, 32'd300, 5'd15, 2'd0, 1);
    kioskReq(3, 32'd400, 5'd16, 2'd1, 1);
    expKiosk(0, -1, 32'd100, 5'd0,  2'd2);
    expKiosk(1,  2, 32'd200, 5'd31, 2'd2);
    expKiosk(2,  2, 32'd300, 5'd15, 2'd0);
    expKiosk(3,  2, 32'd400, 5'd16, 2'd1);
    expKiosk(0,  2, 32'd100, 5'd0,  2'd2);
    applyStimulus(100);

    $display("[TB] manager versus kiosk");
    mgrCommand(2'd1, 2'd1, 11'd0);
    kioskReq(0, 32'd555, 5'd9, 2'd1, 1);
    expMgr(1, 2'd1, 11'd0, -1);
    expKiosk(0, 1, 32'd555, 5'd9, 2'd1);
    applyStimulus(50);

    $display("[TB] manager commands");
    mgrCommand(2'd1, 2'd3, 11'd0);  expMgr(1, 2'd3, 11'd0, -1);  applyStimulus(50);
    mgrCommand(2'd2, 2'd0, 11'd0);  expMgr(2, 2'd0, 11'd0, -1);  applyStimulus(50);
    mgrCommand(2'd2, 2'd0, 11'd30); expMgr(2, 2'd0, 11'd30, -1); applyStimulus(50);
    mgrCommand(2'd3, 2'd0, 11'd0);  expMgr(3, 2'd0, 11'd0, -1);  applyStimulus(50);
    mgrCommand(2'd0, 2'd0, 11'd0);  expMgr(0, 2'd0, 11'd0, -1);  applyStimulus(50);
    mgrCommand(2'd1, 2'd0, 11'd0);  expMgr(1, 2'd0, 11'd0, -1);  applyStimulus(50);

    $display("[TB] reset during issue");
    kioskReq(2, 32'd777, 5'd3, 2'd2, 1);
    pushExp('{gnt: 4'b0100, wr: 1'b0, wset: 2'd0, rstm: 1'b0, ack: 1'b0,
              stu: mStu, seat: mSeat, st: mSt, ban: mBan, lim: mLim}, -1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!kiosk_gnt[2] && n < 10);
    checkOutput("abort_grant_seen", kiosk_gnt, 4'b0100);
    #1 rst_n = 1'b0;
    kiosk_req = '0;
    reqLeft[2] = 0;
    #1;
    checkResetValues("abort");
    mStu = '0; mSeat = '0; mSt = '0; mBan = 2'd2; mLim = 11'd120;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] pointer restarts at kiosk 0");
    kioskReq(3, 32'd333, 5'd1, 2'd1, 1);
    kioskReq(0, 32'd444, 5'd2, 2'd2, 1);
    expKiosk(0, -1, 32'd444, 5'd2, 2'd2);
    expKiosk(3,  2, 32'd333, 5'd1, 2'd1);
    applyStimulus(50);

    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
